// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ioctl download sequencer.
package rom_load_pkg;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_LOAD,
      ST_DRAIN,
      ST_RUN
   } state_t;

   localparam logic [7:0] IDX_ROM   = 8'd0;
   localparam logic [7:0] IDX_MOD   = 8'd1;
   localparam logic [7:0] IDX_DIP   = 8'd254;
   localparam logic [7:0] DIP_RESET = 8'hFF;

   localparam int GAP_W = 4;

endpackage

// File: rtl/rom_load_ctrl_pacer.sv
// ROM write pacer: one-entry skid buffer, inter-write gap counter and overflow flag.
module rom_wr_pacer
   import rom_load_pkg::*;
#(
   parameter int WR_GAP = 3,
   parameter int ROM_AW = 16
)
(
   input  logic              clk_sys,
   input  logic              RESET_N,
   input  logic              i_accept,
   input  logic [ROM_AW-1:0] i_addr,
   input  logic [7:0]        i_data,
   input  logic              i_inLoad,
   output logic              o_dnWr,
   output logic [ROM_AW-1:0] o_dnAddr,
   output logic [7:0]        o_dnData,
   output logic              o_wait,
   output logic              o_overflow,
   output logic              o_idle
);

   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP);

   logic [GAP_W-1:0]  r_gap;
   logic              r_bufFull;
   logic [ROM_AW-1:0] r_bufAddr;
   logic [7:0]        r_bufData;
   logic              r_dnWr;
   logic [ROM_AW-1:0] r_dnAddr;
   logic [7:0]        r_dnData;
   logic              r_overflow;

   logic w_gapActive;
   logic w_issueBuf;
   logic w_issueDirect;
   logic w_toBuf;
   logic w_drop;

   // A buffered byte always goes out before any newly arriving one.
   assign w_gapActive   = (r_gap != '0);
   assign w_issueBuf    = r_bufFull && !w_gapActive;
   assign w_issueDirect = i_accept && !r_bufFull && !w_gapActive;
   assign w_toBuf       = i_accept && !r_bufFull && w_gapActive;
   assign w_drop        = i_accept && r_bufFull;

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_gap      <= '0;
         r_bufFull  <= 1'b0;
         r_bufAddr  <= '0;
         r_bufData  <= '0;
         r_dnWr     <= 1'b0;
         r_dnAddr   <= '0;
         r_dnData   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_dnWr <= w_issueBuf || w_issueDirect;
         if (w_issueBuf) begin
            r_dnAddr <= r_bufAddr;
            r_dnData <= r_bufData;
         end else if (w_issueDirect) begin
            r_dnAddr <= i_addr;
            r_dnData <= i_data;
         end
         if (w_issueBuf || w_issueDirect) begin
            r_gap <= GAP_LOAD;
         end else if (w_gapActive) begin
            r_gap <= r_gap - GAP_W'(1);
         end
         if (w_toBuf) begin
            r_bufFull <= 1'b1;
            r_bufAddr <= i_addr;
            r_bufData <= i_data;
         end else if (w_issueBuf) begin
            r_bufFull <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_dnWr     = r_dnWr;
   assign o_dnAddr   = r_dnAddr;
   assign o_dnData   = r_dnData;
   assign o_wait     = r_bufFull || (w_gapActive && i_inLoad);
   assign o_overflow = r_overflow;
   assign o_idle     = !r_bufFull && !w_gapActive;

endmodule

// File: rtl/rom_load_ctrl.sv
// Download sequencer: routes ioctl bytes by index and owns the core reset.
// Optional ROM_LOAD_CHECKSUM_EN adds the rom_sum output.
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter int WR_GAP      = 3,
   parameter int HOLD_CYCLES = 1024,
   parameter int ROM_AW      = 16
)
(
   input  logic              clk_sys,
   input  logic              RESET_N,
   input  logic              rst_req,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   output logic [ROM_AW-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic [7:0]        mod_id,
   output logic              mod_valid,
   output logic [63:0]       dip_bank,
   output logic              core_reset,
`ifdef ROM_LOAD_CHECKSUM_EN
   output logic [15:0]       rom_sum,
`endif
   output logic              wr_overflow
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_holdCnt;
   logic             w_reload;
   logic             w_pacerIdle;
   logic             w_romAccept;
   logic             w_modAccept;
   logic             w_dipAccept;
   logic [7:0]       r_modId;
   logic             r_modValid;
   logic [63:0]      r_dipBank;

   assign w_romAccept = ioctl_wr && (ioctl_index == IDX_ROM) && ((ioctl_addr >> ROM_AW) == 25'd0);
   assign w_modAccept = ioctl_wr && (ioctl_index == IDX_MOD) && (ioctl_addr == 25'd0);
   assign w_dipAccept = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);

   // A download overrides everything, including a pending reset request.
   always_comb begin
      w_nextState = r_state;
      w_reload    = 1'b0;
      if (ioctl_download) begin
         w_nextState = ST_LOAD;
         w_reload    = 1'b1;
      end else begin
         case (r_state)
            ST_LOAD: w_nextState = ST_DRAIN;
            ST_DRAIN: begin
               if (w_pacerIdle) begin
                  w_nextState = ST_HOLD;
                  w_reload    = 1'b1;
               end
            end
            ST_HOLD: begin
               if (rst_req) begin
                  w_reload = 1'b1;
               end else if (r_holdCnt == '0) begin
                  w_nextState = ST_RUN;
               end
            end
            ST_RUN: begin
               if (rst_req) begin
                  w_nextState = ST_HOLD;
                  w_reload    = 1'b1;
               end
            end
            default: begin
               w_nextState = ST_HOLD;
               w_reload    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_state   <= ST_HOLD;
         r_holdCnt <= CNT_LOAD;
      end else begin
         r_state <= w_nextState;
         if (w_reload) begin
            r_holdCnt <= CNT_LOAD;
         end else if ((r_state == ST_HOLD) && (r_holdCnt != '0)) begin
            r_holdCnt <= r_holdCnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_modId    <= '0;
         r_modValid <= 1'b0;
         r_dipBank  <= {8{DIP_RESET}};
      end else begin
         if (w_modAccept) begin
            r_modId    <= ioctl_dout;
            r_modValid <= 1'b1;
         end
         if (w_dipAccept) begin
            r_dipBank[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
         end
      end
   end

   rom_wr_pacer #(
      .WR_GAP (WR_GAP),
      .ROM_AW (ROM_AW)
   ) u_pacer (
      .clk_sys    (clk_sys),
      .RESET_N    (RESET_N),
      .i_accept   (w_romAccept),
      .i_addr     (ioctl_addr[ROM_AW-1:0]),
      .i_data     (ioctl_dout),
      .i_inLoad   (r_state == ST_LOAD),
      .o_dnWr     (dn_wr),
      .o_dnAddr   (dn_addr),
      .o_dnData   (dn_data),
      .o_wait     (ioctl_wait),
      .o_overflow (wr_overflow),
      .o_idle     (w_pacerIdle)
   );

`ifdef ROM_LOAD_CHECKSUM_EN
   logic [15:0] r_romSum;

   // Only bytes issued while a download is being handled are summed.
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_romSum <= '0;
      end else if ((w_nextState == ST_LOAD) && (r_state != ST_LOAD)) begin
         r_romSum <= '0;
      end else if (dn_wr && ((r_state == ST_LOAD) || (r_state == ST_DRAIN))) begin
         r_romSum <= r_romSum + {8'd0, dn_data};
      end
   end

   assign rom_sum = r_romSum;
`endif

   assign mod_id     = r_modId;
   assign mod_valid  = r_modValid;
   assign dip_bank   = r_dipBank;
   assign core_reset = (r_state != ST_RUN);

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl against a cycle-timed behavioural model.
module tb_rom_load_ctrl;

   localparam int WR_GAP      = 3;
   localparam int HOLD_CYCLES = 1024;
   localparam int ROM_AW      = 16;

   localparam int P_HOLD  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_DRAIN = 2;
   localparam int P_RUN   = 3;

   logic              clk_sys = 1'b0;
   logic              RESET_N;
   logic              rst_req;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait;
   logic [ROM_AW-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              dn_wr;
   logic [7:0]        mod_id;
   logic              mod_valid;
   logic [63:0]       dip_bank;
   logic              core_reset;
   logic              wr_overflow;
`ifdef ROM_LOAD_CHECKSUM_EN
   logic [15:0]       rom_sum;
`endif

   rom_load_ctrl #(
      .WR_GAP      (WR_GAP),
      .HOLD_CYCLES (HOLD_CYCLES),
      .ROM_AW      (ROM_AW)
   ) dut (
      .clk_sys        (clk_sys),
      .RESET_N        (RESET_N),
      .rst_req        (rst_req),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .mod_id         (mod_id),
      .mod_valid      (mod_valid),
      .dip_bank       (dip_bank),
      .core_reset     (core_reset),
`ifdef ROM_LOAD_CHECKSUM_EN
      .rom_sum        (rom_sum),
`endif
      .wr_overflow    (wr_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int nChecks = 0;
   int nErrors = 0;

   // Model state; every value describes the cycle currently being sampled.
   int                mCycle = 0;
   int                mPhase;
   int                mHoldStart;
   int                mLastIssue;
   bit                mBufValid;
   logic [ROM_AW-1:0] mBufAddr;
   logic [7:0]        mBufData;
   logic [ROM_AW-1:0] mDnAddr;
   logic [7:0]        mDnData;
   bit                mOverflow;
   logic [7:0]        mModId;
   bit                mModValid;
   logic [63:0]       mDip;
   logic [15:0]       mSum;
   int                lastSeenWr;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, mCycle);
      end
   endtask

   function automatic bit gapActive(input int c);
      return (c >= mLastIssue) && ((c - mLastIssue) < WR_GAP);
   endfunction

   // Predicts the next cycle from the current model state and the inputs now applied.
   task automatic modelStep();
      int nxt;
      int nextPhase;
      bit gapAct;
      bit bufNow;
      bit idleNow;
      bit romAcc;
      nxt = mCycle + 1;
      if (!RESET_N) begin
         mPhase     = P_HOLD;
         mHoldStart = nxt;
         mLastIssue = -1000;
         mBufValid  = 1'b0;
         mBufAddr   = '0;
         mBufData   = '0;
         mDnAddr    = '0;
         mDnData    = '0;
         mOverflow  = 1'b0;
         mModId     = '0;
         mModValid  = 1'b0;
         mDip       = {64{1'b1}};
         mSum       = '0;
         lastSeenWr = -1;
      end else begin
         gapAct    = gapActive(mCycle);
         bufNow    = mBufValid;
         idleNow   = !bufNow && !gapAct;
         nextPhase = mPhase;
         if (ioctl_download) begin
            nextPhase = P_LOAD;
         end else if (mPhase == P_LOAD) begin
            nextPhase = P_DRAIN;
         end else if (mPhase == P_DRAIN) begin
            if (idleNow) begin
               nextPhase  = P_HOLD;
               mHoldStart = nxt;
            end
         end else if (rst_req) begin
            nextPhase  = P_HOLD;
            mHoldStart = nxt;
         end else if ((mPhase == P_HOLD) && ((nxt - mHoldStart) >= HOLD_CYCLES)) begin
            nextPhase = P_RUN;
         end

         if ((nextPhase == P_LOAD) && (mPhase != P_LOAD)) begin
            mSum = '0;
         end else if ((mLastIssue == mCycle) && ((mPhase == P_LOAD) || (mPhase == P_DRAIN))) begin
            mSum = mSum + {8'd0, mDnData};
         end

         romAcc = ioctl_wr && (ioctl_index == 8'd0) && (ioctl_addr < (25'd1 << ROM_AW));
         if (bufNow && !gapAct) begin
            mDnAddr    = mBufAddr;
            mDnData    = mBufData;
            mLastIssue = nxt;
            mBufValid  = 1'b0;
         end
         if (romAcc) begin
            if (bufNow) begin
               mOverflow = 1'b1;
            end else if (gapAct) begin
               mBufValid = 1'b1;
               mBufAddr  = ioctl_addr[ROM_AW-1:0];
               mBufData  = ioctl_dout;
            end else begin
               mDnAddr    = ioctl_addr[ROM_AW-1:0];
               mDnData    = ioctl_dout;
               mLastIssue = nxt;
            end
         end

         if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
            mModId    = ioctl_dout;
            mModValid = 1'b1;
         end
         if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'd8)) begin
            mDip[8*int'(ioctl_addr) +: 8] = ioctl_dout;
         end
         mPhase = nextPhase;
      end
   endtask

   task automatic compareAll();
      checkOutput("coreReset", core_reset, mPhase != P_RUN);
      checkOutput("ioctlWait", ioctl_wait, mBufValid || (gapActive(mCycle) && (mPhase == P_LOAD)));
      checkOutput("dnWr", dn_wr, mLastIssue == mCycle);
      checkOutput("dnAddr", dn_addr, mDnAddr);
      checkOutput("dnData", dn_data, mDnData);
      checkOutput("wrOverflow", wr_overflow, mOverflow);
      checkOutput("modId", mod_id, mModId);
      checkOutput("modValid", mod_valid, mModValid);
      checkOutput("dipBank", dip_bank, mDip);
`ifdef ROM_LOAD_CHECKSUM_EN
      checkOutput("romSum", rom_sum, mSum);
`endif
      if (dn_wr === 1'b1) begin
         if (lastSeenWr >= 0) begin
            checkOutput("wrSpacing", (mCycle - lastSeenWr) > WR_GAP, 1'b1);
         end
         lastSeenWr = mCycle;
      end
   endtask

   // One clock: drive inputs, advance the model, sample at the falling edge.
   task automatic applyStimulus(input logic rn, input logic rq, input logic dl, input logic wr,
                                input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dout);
      RESET_N        = rn;
      rst_req        = rq;
      ioctl_download = dl;
      ioctl_wr       = wr;
      ioctl_index    = idx;
      ioctl_addr     = addr;
      ioctl_dout     = dout;
      modelStep();
      @(posedge clk_sys);
      mCycle++;
      @(negedge clk_sys);
      compareAll();
   endtask

   task automatic idle(input logic dl);
      applyStimulus(1'b1, 1'b0, dl, 1'b0, 8'd0, 25'd0, 8'd0);
   endtask

   task automatic waitRun();
      int n;
      n = 0;
      while ((core_reset !== 1'b0) && (n < 3000)) begin
         idle(1'b0);
         n++;
      end
      checkOutput("reachRun", core_reset, 1'b0);
   endtask

   initial begin
      int cnt;
      int nWr;
      logic [63:0] dipSaved;
      logic dlState;
      logic wrR;
      logic [7:0] idxR;
      logic [24:0] addrR;
      int sel;

      RESET_N        = 1'b0;
      rst_req        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      @(negedge clk_sys);

      // Reset release and the power-on hold.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
      checkOutput("rstDip", dip_bank, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("rstModId", mod_id, 8'd0);
      cnt = 0;
      while ((core_reset === 1'b1) && (cnt < 2000)) begin
         cnt++;
         idle(1'b0);
      end
      checkOutput("holdLen", cnt, HOLD_CYCLES);
      repeat (3) idle(1'b0);

      // Four paced ROM bytes, one strobe every five cycles.
      idle(1'b1);
      nWr = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'(i), 8'(8'h30 + i));
         if (dn_wr === 1'b1) nWr++;
         for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            if (dn_wr === 1'b1) nWr++;
         end
      end
      checkOutput("romWrCount", nWr, 4);
      // One DRAIN cycle precedes the hold.
      idle(1'b0);
      cnt = 0;
      while ((core_reset === 1'b1) && (cnt < 3000)) begin
         cnt++;
         idle(1'b0);
      end
      checkOutput("holdAfterDl", cnt, HOLD_CYCLES + 1);

      // Back-to-back strobes: buffer, then overflow on the third.
      idle(1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'h10, 8'hA1);
      checkOutput("b2bFirstWr", dn_wr, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'h11, 8'hB2);
      checkOutput("b2bWaitHigh", ioctl_wait, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'h12, 8'hC3);
      checkOutput("b2bOverflow", wr_overflow, 1'b1);
      idle(1'b1);
      checkOutput("b2bNoWrT4", dn_wr, 1'b0);
      idle(1'b1);
      checkOutput("b2bWrT5", dn_wr, 1'b1);
      checkOutput("b2bAddrT5", dn_addr, 16'h0011);
      checkOutput("b2bDataT5", dn_data, 8'hB2);
      repeat (4) idle(1'b1);
      waitRun();

      // Mod and DIP routing while running.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 25'd0, 8'd15);
      checkOutput("modId15", mod_id, 8'd15);
      checkOutput("modValidSet", mod_valid, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 25'd1, 8'h77);
      checkOutput("modAddr1Ignored", mod_id, 8'd15);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd254, 25'd2, 8'hA5);
      checkOutput("dipByte2", dip_bank[23:16], 8'hA5);
      dipSaved = dip_bank;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd254, 25'd8, 8'h00);
      checkOutput("dipAddr8Ignored", dip_bank, dipSaved);
      checkOutput("runStill", core_reset, 1'b0);

      // Reset pulse mid-download with a byte sitting in the buffer.
      idle(1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'h5, 8'h55);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'h6, 8'h66);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
      checkOutput("midRstCore", core_reset, 1'b1);
      checkOutput("midRstDnWr", dn_wr, 1'b0);
      checkOutput("midRstDnAddr", dn_addr, 16'h0000);
      checkOutput("midRstWait", ioctl_wait, 1'b0);
      checkOutput("midRstModId", mod_id, 8'd0);
      checkOutput("midRstModValid", mod_valid, 1'b0);
      checkOutput("midRstDip", dip_bank, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("midRstOverflow", wr_overflow, 1'b0);
      idle(1'b1);
      checkOutput("midRstLoad", core_reset, 1'b1);
      repeat (6) idle(1'b1);
      checkOutput("midRstBufLost", dn_wr, 1'b0);
      waitRun();

      // Randomised traffic, including occasional protocol violations and resets.
      dlState = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 99) < 3) dlState = !dlState;
         wrR = ($urandom_range(0, 3) == 0) && ((ioctl_wait !== 1'b1) || ($urandom_range(0, 29) == 0));
         sel = $urandom_range(0, 9);
         if (sel < 5)      idxR = 8'd0;
         else if (sel < 7) idxR = 8'd254;
         else if (sel < 8) idxR = 8'd1;
         else              idxR = 8'($urandom_range(2, 253));
         if ($urandom_range(0, 4) == 0) addrR = 25'($urandom());
         else                           addrR = 25'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 499) != 0), ($urandom_range(0, 199) == 0),
                       dlState, wrR, idxR, addrR, 8'($urandom()));
      end
      repeat (8) idle(1'b0);

`ifdef ROM_LOAD_CHECKSUM_EN
      // 300 bytes of 0xFF sum to 0x2AD4 modulo 2^16.
      idle(1'b1);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 25'(i), 8'hFF);
         repeat (WR_GAP + 1) idle(1'b1);
      end
      checkOutput("romSum300", rom_sum, 16'h2AD4);
      waitRun();
`endif

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
